// File: rtl/tiny_eth_tx.sv
// tiny_eth_tx: serial Ethernet frame transmitter.
//
// Accepts payload bytes on a valid/ready byte stream and sends each frame one
// bit per tx_clk, LSB first. A frame is 7 bytes of 0x55 preamble, the 0xD5 SFD,
// the payload, zero padding up to MIN_FRAME bytes, and the CRC-32 FCS. A fixed
// gap of IFG_BITS quiet cycles follows every frame.
//
// Ports:
//   tx_clk     : the only clock, rising edge
//   rst        : asynchronous active-low reset
//   in_data    : payload byte
//   in_valid   : in_data / in_last are valid
//   in_last    : current byte is the final payload byte
//   in_ready   : byte is taken on this edge when in_valid is high
//   serial_out : serial line, LSB of each byte first
//   tx_en      : high while preamble .. FCS bits are on serial_out
//   busy       : high whenever the sequencer is not idle
//   tx_err     : one-cycle pulse when a byte is not supplied in time (underrun)
//
// The state machine runs one cycle ahead of the line: the state held in a
// cycle selects the bit driven onto serial_out at the following edge. The one
// exception is the first bit of a payload byte, which comes straight from
// in_data on the edge that accepts it. IFG_BITS is expected to be at least 2.
module tiny_eth_tx #(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BITS  = 96
) (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       serial_out,
  output logic       tx_en,
  output logic       busy,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SFD      = 3'd2,
    S_DATA     = 3'd3,
    S_PAD      = 3'd4,
    S_FCS      = 3'd5,
    S_IFG      = 3'd6
  } state_t;

  localparam logic [10:0] MIN_L    = 11'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BITS - 1);
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  // One bit of the reflected CRC-32 (polynomial 0xEDB88320).
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    logic [31:0] s;
    s = {1'b0, c[31:1]};
    return (c[0] ^ b) ? (s ^ 32'hEDB88320) : s;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;   // payload + pad bytes, saturating
  logic [15:0] aux_q, aux_d;             // preamble byte / FCS bit / IFG cycle index
  logic [7:0]  sr_q, sr_d;
  logic        last_q, last_d;
  logic [31:0] crc_q, crc_d;
  logic        in_ready_q, in_ready_d;
  logic        serial_q, serial_d;
  logic        tx_en_q, tx_en_d;
  logic        busy_q, busy_d;
  logic        tx_err_q, tx_err_d;
  logic [10:0] byte_inc_s;

  assign in_ready   = in_ready_q;
  assign serial_out = serial_q;
  assign tx_en      = tx_en_q;
  assign busy       = busy_q;
  assign tx_err     = tx_err_q;

  assign byte_inc_s = (byte_cnt_q == 11'd2047) ? byte_cnt_q : (byte_cnt_q + 11'd1);

  // Next-state, counter, CRC and output computation.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    aux_d      = aux_q;
    sr_d       = sr_q;
    last_d     = last_q;
    crc_d      = crc_q;
    in_ready_d = 1'b0;
    serial_d   = 1'b0;
    tx_en_d    = 1'b0;
    tx_err_d   = 1'b0;
    busy_d     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        crc_d = 32'hFFFFFFFF;
        if (in_valid) begin
          state_d   = S_PREAMBLE;
          bit_cnt_d = 3'd0;
          aux_d     = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREAMBLE: begin
        serial_d  = ~bit_cnt_q[0];   // 0x55 LSB first: 1,0,1,0,...
        tx_en_d   = 1'b1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (aux_q == 16'd6) begin
            state_d = S_SFD;
            aux_d   = 16'd0;
          end else begin
            aux_d = aux_q + 16'd1;
          end
        end else begin
          aux_d = aux_q;
        end
      end
      S_SFD: begin
        serial_d   = SFD_BYTE[bit_cnt_q];
        tx_en_d    = 1'b1;
        crc_d      = 32'hFFFFFFFF;
        byte_cnt_d = 11'd0;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d    = S_DATA;
          in_ready_d = 1'b1;
        end else begin
          state_d = S_SFD;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == 3'd0) begin
          // in_ready is high in this cycle: the byte must arrive on this edge.
          if (in_valid) begin
            sr_d       = in_data;
            last_d     = in_last;
            serial_d   = in_data[0];
            tx_en_d    = 1'b1;
            crc_d      = crc_step(crc_q, in_data[0]);
            bit_cnt_d  = 3'd1;
            byte_cnt_d = byte_inc_s;
          end else begin
            // Underrun: abandon the frame without an FCS. This cycle is the
            // first quiet cycle of the gap.
            tx_err_d  = 1'b1;
            state_d   = S_IFG;
            aux_d     = 16'd1;
            bit_cnt_d = 3'd0;
          end
        end else begin
          serial_d  = sr_q[bit_cnt_q];
          tx_en_d   = 1'b1;
          crc_d     = crc_step(crc_q, sr_q[bit_cnt_q]);
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (!last_q) begin
              state_d    = S_DATA;
              in_ready_d = 1'b1;
            end else if (byte_cnt_q < MIN_L) begin
              state_d = S_PAD;
            end else begin
              state_d = S_FCS;
              aux_d   = 16'd0;
            end
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_PAD: begin
        serial_d  = 1'b0;
        tx_en_d   = 1'b1;
        crc_d     = crc_step(crc_q, 1'b0);
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd0) begin
          byte_cnt_d = byte_inc_s;
        end else begin
          byte_cnt_d = byte_cnt_q;
        end
        if ((bit_cnt_q == 3'd7) && (byte_cnt_q >= MIN_L)) begin
          state_d = S_FCS;
          aux_d   = 16'd0;
        end else begin
          state_d = S_PAD;
        end
      end
      S_FCS: begin
        // CRC register is left untouched here; bits go out complemented.
        serial_d = ~crc_q[aux_q[4:0]];
        tx_en_d  = 1'b1;
        if (aux_q == 16'd31) begin
          state_d = S_IFG;
          aux_d   = 16'd0;
        end else begin
          aux_d = aux_q + 16'd1;
        end
      end
      S_IFG: begin
        if (aux_q >= IFG_LAST) begin
          state_d = S_IDLE;
          aux_d   = 16'd0;
        end else begin
          aux_d = aux_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge tx_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 11'd0;
      aux_q      <= 16'd0;
      sr_q       <= 8'd0;
      last_q     <= 1'b0;
      crc_q      <= 32'hFFFFFFFF;
      in_ready_q <= 1'b0;
      serial_q   <= 1'b0;
      tx_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      aux_q      <= aux_d;
      sr_q       <= sr_d;
      last_q     <= last_d;
      crc_q      <= crc_d;
      in_ready_q <= in_ready_d;
      serial_q   <= serial_d;
      tx_en_q    <= tx_en_d;
      busy_q     <= busy_d;
      tx_err_q   <= tx_err_d;
    end
  end

endmodule

// File: tb/tb_tiny_eth_tx.sv
// Directed testbench for tiny_eth_tx. Two instances share clock and reset:
// u_nopad (MIN_FRAME=0) and u_pad (MIN_FRAME=60). One stimulus process feeds
// a byte stream to the selected instance and records its line activity.
module tb_tiny_eth_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] d_a, d_b;
  logic       v_a, v_b, l_a, l_b;
  logic       rdy_a, ser_a, en_a, busy_a, err_a;
  logic       rdy_b, ser_b, en_b, busy_b, err_b;

  tiny_eth_tx #(.MIN_FRAME(0), .IFG_BITS(96)) u_nopad (
    .tx_clk(clk), .rst(rst), .in_data(d_a), .in_valid(v_a), .in_last(l_a),
    .in_ready(rdy_a), .serial_out(ser_a), .tx_en(en_a), .busy(busy_a), .tx_err(err_a)
  );

  tiny_eth_tx #(.MIN_FRAME(60), .IFG_BITS(96)) u_pad (
    .tx_clk(clk), .rst(rst), .in_data(d_b), .in_valid(v_b), .in_last(l_b),
    .in_ready(rdy_b), .serial_out(ser_b), .tx_en(en_b), .busy(busy_b), .tx_err(err_b)
  );

  int tests = 0;
  int fails = 0;
  int sel;
  int cyc;

  logic [7:0] st_d [0:127];
  logic       st_l [0:127];
  int st_n, stop_at, skip_to;

  logic cap [0:1][0:1023];
  int capn [0:1];
  int rise_c [0:1];
  int fall_c [0:1];
  int err_cnt, err_c, first_rdy, busy_rise, busy_fall, busy_gap;
  logic err_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference reflected CRC-32 over one byte.
  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [7:0] cap_byte(input int f, input int k);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = cap[f][8*k+b];
    return r;
  endfunction

  task automatic set_in(input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin v_a = v; d_a = d; l_a = l; end
    else          begin v_b = v; d_b = d; l_b = l; end
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic l);
    st_d[i] = d;
    st_l[i] = l;
  endtask

  // Feed the stream for ncyc cycles and record what the selected DUT sends.
  // Call just after a rising edge.
  task automatic run(input int ncyc);
    logic o_r, o_s, o_e, o_b, o_x;
    bit   e, prev_e, cur_v, acc, und;
    int   idx, f;
    idx = 0; f = -1; prev_e = 1'b0; cyc = 0;
    capn = '{0, 0}; rise_c = '{-1, -1}; fall_c = '{-1, -1};
    err_cnt = 0; err_c = -1; err_en = 1'bx; first_rdy = -1;
    busy_rise = -1; busy_fall = -1; busy_gap = 0;
    cur_v = (idx < st_n) && (idx != stop_at);
    if (cur_v) set_in(1'b1, st_d[idx], st_l[idx]);
    else       set_in(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (sel == 0) begin o_r = rdy_a; o_s = ser_a; o_e = en_a; o_b = busy_a; o_x = err_a; end
      else          begin o_r = rdy_b; o_s = ser_b; o_e = en_b; o_b = busy_b; o_x = err_b; end
      e = (o_e === 1'b1);
      if (e && !prev_e) begin f++; if (f < 2) rise_c[f] = cyc; end
      if (!e && prev_e && f >= 0 && f < 2) fall_c[f] = cyc;
      if (e && f >= 0 && f < 2 && capn[f] < 1024) begin cap[f][capn[f]] = o_s; capn[f]++; end
      if (o_x === 1'b1) begin err_cnt++; err_c = cyc; err_en = o_e; end
      if (o_r === 1'b1 && first_rdy < 0) first_rdy = cyc;
      if (o_b === 1'b1 && busy_rise < 0) busy_rise = cyc;
      if (f == 0 && fall_c[0] >= 0 && o_b !== 1'b1) begin
        busy_gap++;
        if (busy_fall < 0) busy_fall = cyc;
      end
      acc = (o_r === 1'b1) && cur_v;
      und = (o_r === 1'b1) && !cur_v && (idx == stop_at);
      prev_e = e;
      @(posedge clk);
      cyc++;
      #1;
      if (acc)      idx++;
      else if (und) idx = skip_to;
      cur_v = (idx < st_n) && (idx != stop_at);
      if (cur_v) set_in(1'b1, st_d[idx], st_l[idx]);
      else       set_in(1'b0, 8'h00, 1'b0);
    end
  endtask

  // Compare recorded frame f against preamble, SFD, payload, pad and FCS.
  task automatic check_frame(input string tag, input int f, input int start, input int n, input int minf);
    logic [7:0]  e [0:127];
    logic [31:0] c;
    int en, bad;
    en = 0;
    for (int k = 0; k < 7; k++) begin e[en] = 8'h55; en++; end
    e[en] = 8'hD5; en++;
    for (int k = 0; k < n; k++) begin e[en] = st_d[start+k]; en++; end
    while (en - 8 < minf) begin e[en] = 8'h00; en++; end
    c = 32'hFFFFFFFF;
    for (int k = 8; k < en; k++) c = crc_upd(c, e[k]);
    c = ~c;
    for (int k = 0; k < 4; k++) begin e[en] = c[8*k +: 8]; en++; end
    check({tag, "_bits"}, 32'(capn[f]), 32'(en*8));
    check({tag, "_en_len"}, 32'(fall_c[f] - rise_c[f]), 32'(en*8));
    bad = -1;
    for (int k = 0; k < en; k++) if (bad < 0 && cap_byte(f, k) !== e[k]) bad = k;
    check({tag, "_bytes"}, 32'(bad), 32'hFFFFFFFF);
  endtask

  initial begin
    logic bad;
    rst = 1'b0;
    v_a = 1'b0; d_a = 8'h00; l_a = 1'b0;
    v_b = 1'b0; d_b = 8'h00; l_b = 1'b0;
    sel = 0; st_n = 0; stop_at = -1; skip_to = 0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs_nopad", 32'({rdy_a, ser_a, en_a, busy_a, err_a}), 32'h0);
    check("rst_outs_pad",   32'({rdy_b, ser_b, en_b, busy_b, err_b}), 32'h0);
    rst = 1'b1;
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if ({rdy_a, ser_a, en_a, busy_a, err_a, rdy_b, ser_b, en_b, busy_b, err_b} !== 10'b0) bad = 1'b1;
    end
    check("idle_200", 32'(bad), 32'h0);

    // CRC check, no padding: "123456789"
    sel = 0;
    for (int i = 0; i < 9; i++) load(i, 8'h31 + 8'(i), (i == 8));
    st_n = 9; stop_at = -1;
    @(posedge clk); #1;
    run(400);
    check("crc_first_bit_cyc", 32'(rise_c[0]), 32'd2);
    check("crc_busy_rise",     32'(busy_rise), 32'd2);
    check("crc_first_ready",   32'(first_rdy), 32'd65);
    check("crc_fcs0", 32'(cap_byte(0, 17)), 32'h26);
    check("crc_fcs1", 32'(cap_byte(0, 18)), 32'h39);
    check("crc_fcs2", 32'(cap_byte(0, 19)), 32'hF4);
    check("crc_fcs3", 32'(cap_byte(0, 20)), 32'hCB);
    check_frame("crc", 0, 0, 9, 0);
    check("crc_en_168",  32'(fall_c[0] - rise_c[0]), 32'd168);
    check("crc_ifg_busy", 32'(busy_fall - fall_c[0]), 32'd96);
    check("crc_quiet",   32'(rise_c[1]), 32'hFFFFFFFF);
    check("crc_no_err",  32'(err_cnt), 32'd0);

    // Padding: single byte 0xAB, MIN_FRAME=60
    sel = 1;
    load(0, 8'hAB, 1'b1);
    st_n = 1; stop_at = -1;
    @(posedge clk); #1;
    run(800);
    check("pad_first_bit_cyc", 32'(rise_c[0]), 32'd2);
    check("pad_en_576", 32'(fall_c[0] - rise_c[0]), 32'd576);
    check("pad_byte0",  32'(cap_byte(0, 8)),  32'hAB);
    check("pad_first0", 32'(cap_byte(0, 9)),  32'h00);
    check("pad_last0",  32'(cap_byte(0, 67)), 32'h00);
    check_frame("pad", 0, 0, 1, 60);
    check("pad_no_err", 32'(err_cnt), 32'd0);

    // Underrun at the third byte's slot, then a normal frame
    sel = 1;
    load(0, 8'h11, 1'b0); load(1, 8'h22, 1'b0); load(2, 8'h33, 1'b0); load(3, 8'h44, 1'b1);
    load(4, 8'h5A, 1'b0); load(5, 8'hC3, 1'b1);
    st_n = 6; stop_at = 2; skip_to = 4;
    @(posedge clk); #1;
    run(1200);
    check("und_err_count",   32'(err_cnt), 32'd1);
    check("und_err_with_en", 32'(err_en), 32'h0);
    check("und_err_at_fall", 32'(err_c), 32'(fall_c[0]));
    check("und_en_len",      32'(fall_c[0] - rise_c[0]), 32'd80);
    check("und_bits",        32'(capn[0]), 32'd80);
    check("und_b0",          32'(cap_byte(0, 8)), 32'h11);
    check("und_b1",          32'(cap_byte(0, 9)), 32'h22);
    check("und_gap_ge97",    32'((rise_c[1] - fall_c[0]) >= 97), 32'h1);
    check_frame("und_next", 1, 4, 2, 60);
    stop_at = -1;

    // Back-to-back frames with in_valid held high
    sel = 0;
    load(0, 8'h01, 1'b0); load(1, 8'h02, 1'b0); load(2, 8'h03, 1'b1);
    load(3, 8'hF0, 1'b0); load(4, 8'h0F, 1'b1);
    st_n = 5; stop_at = -1;
    @(posedge clk); #1;
    run(600);
    check_frame("b2b_a", 0, 0, 3, 0);
    check_frame("b2b_b", 1, 3, 2, 0);
    check("b2b_gap_97",    32'(rise_c[1] - fall_c[0]), 32'd97);
    check("b2b_busy_low1", 32'(busy_gap), 32'd1);
    check("b2b_no_err",    32'(err_cnt), 32'd0);

    // Reset in the middle of DATA
    sel = 1;
    load(0, 8'hC0, 1'b0); load(1, 8'hFF, 1'b0); load(2, 8'hEE, 1'b0); load(3, 8'h0D, 1'b1);
    st_n = 4; stop_at = -1;
    @(posedge clk); #1;
    run(80);
    check("mr_pre_en", 32'(en_b), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("mr_outs_async", 32'({rdy_b, ser_b, en_b, busy_b, err_b}), 32'h0);
    set_in(1'b0, 8'h00, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_idle_after", 32'({rdy_b, ser_b, en_b, busy_b, err_b}), 32'h0);
    @(posedge clk); #1;
    run(800);
    check("mr_first_bit_cyc", 32'(rise_c[0]), 32'd2);
    check_frame("mr", 0, 0, 4, 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
